// File: rtl/stopwatch_pkg.sv
// +--------------------------------------------------------------------+
// | stopwatch_pkg : shared state encoding and BCD digit constants       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  localparam int                 c_digit_w    = 4;
  localparam logic [c_digit_w-1:0] c_limit_nine = 4'd9;
  localparam logic [c_digit_w-1:0] c_limit_five = 4'd5;

endpackage

`default_nettype wire

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// +--------------------------------------------------------------------+
// | bcd_digit : one BCD counter stage, wraps at LIMIT with carry out    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [c_digit_w-1:0] LIMIT = c_limit_nine
) (
  input  logic                 clock_5,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_inc,
  output logic [c_digit_w-1:0] o_value,
  output logic                 o_carry
);

  logic [c_digit_w-1:0] r_value;

  // Carry is combinational so the whole chain ripples within the tick cycle.
  assign o_carry = i_inc && (r_value == LIMIT);
  assign o_value = r_value;

  always_ff @(posedge clock_5 or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
    end else if (i_clear) begin
      r_value <= '0;
    end else if (i_inc) begin
      r_value <= o_carry ? '0 : r_value + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// +--------------------------------------------------------------------+
// | stopwatch_ctrl : key-driven BCD stopwatch M:SS.T with wrap pulse    |
// | Optional macro STOPWATCH_LAP_EN adds a LAP (frozen display) state.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 9
) (
  input  logic        clock_5,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        key_start_n,
  input  logic        key_clear_n,
  output logic [15:0] digits,
  output logic        running,
  output logic        wrap_pulse
);

  localparam logic [c_digit_w-1:0] c_max_min = 4'(MAX_MIN);

  logic      r_start_s1, r_start_s2, r_start_prev;
  logic      r_clear_s1, r_clear_s2, r_clear_prev;
  logic [1:0] r_sync_fill;
  logic      w_start_ev, w_clear_ev;

  sw_state_t r_state, w_state_next;
  logic      w_count_en, w_count_clr;
  logic      r_running, r_wrap;

  logic [15:0] w_count;
  logic      w_carry_tenths, w_carry_units, w_carry_tens, w_carry_min;

  // Edge history only arms once the synchronizer holds real pin samples,
  // so a key held low through reset release never yields an event.
  always_ff @(posedge clock_5 or negedge reset) begin
    if (!reset) begin
      r_start_s1   <= 1'b1;
      r_start_s2   <= 1'b1;
      r_clear_s1   <= 1'b1;
      r_clear_s2   <= 1'b1;
      r_sync_fill  <= 2'b00;
      r_start_prev <= 1'b0;
      r_clear_prev <= 1'b0;
    end else begin
      r_start_s1   <= key_start_n;
      r_start_s2   <= r_start_s1;
      r_clear_s1   <= key_clear_n;
      r_clear_s2   <= r_clear_s1;
      r_sync_fill  <= {r_sync_fill[0], 1'b1};
      r_start_prev <= r_start_s2 & r_sync_fill[1];
      r_clear_prev <= r_clear_s2 & r_sync_fill[1];
    end
  end

  assign w_start_ev = r_start_prev & ~r_start_s2;
  assign w_clear_ev = r_clear_prev & ~r_clear_s2;

  always_ff @(posedge clock_5 or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == RUN) || (w_state_next == LAP);
      r_wrap    <= w_carry_min;
    end
  end

  // Start always wins over a simultaneous clear.
  always_comb begin
    w_state_next = r_state;
    w_count_clr  = 1'b0;
    w_count_en   = tick_in && ((r_state == RUN) || (r_state == LAP));
    case (r_state)
      IDLE: begin
        if (w_start_ev) w_state_next = RUN;
      end
      RUN: begin
        if (w_start_ev) begin
          w_state_next = PAUSE;
        end
`ifdef STOPWATCH_LAP_EN
        else if (w_clear_ev) begin
          w_state_next = LAP;
        end
`endif
      end
      PAUSE: begin
        if (w_start_ev) begin
          w_state_next = RUN;
        end else if (w_clear_ev) begin
          w_state_next = IDLE;
          w_count_clr  = 1'b1;
        end
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (w_start_ev) begin
          w_state_next = PAUSE;
        end else if (w_clear_ev) begin
          w_state_next = RUN;
        end
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

  bcd_digit #(.LIMIT(c_limit_nine)) u_tenths (
    .clock_5 (clock_5),
    .reset   (reset),
    .i_clear (w_count_clr),
    .i_inc   (w_count_en),
    .o_value (w_count[3:0]),
    .o_carry (w_carry_tenths)
  );

  bcd_digit #(.LIMIT(c_limit_nine)) u_sec_units (
    .clock_5 (clock_5),
    .reset   (reset),
    .i_clear (w_count_clr),
    .i_inc   (w_carry_tenths),
    .o_value (w_count[7:4]),
    .o_carry (w_carry_units)
  );

  bcd_digit #(.LIMIT(c_limit_five)) u_sec_tens (
    .clock_5 (clock_5),
    .reset   (reset),
    .i_clear (w_count_clr),
    .i_inc   (w_carry_units),
    .o_value (w_count[11:8]),
    .o_carry (w_carry_tens)
  );

  bcd_digit #(.LIMIT(c_max_min)) u_minutes (
    .clock_5 (clock_5),
    .reset   (reset),
    .i_clear (w_count_clr),
    .i_inc   (w_carry_tens),
    .o_value (w_count[15:12]),
    .o_carry (w_carry_min)
  );

`ifdef STOPWATCH_LAP_EN
  logic [15:0] r_freeze;

  // Captures the value on display in the cycle the lap is taken.
  always_ff @(posedge clock_5 or negedge reset) begin
    if (!reset) begin
      r_freeze <= '0;
    end else if ((r_state == RUN) && (w_state_next == LAP)) begin
      r_freeze <= w_count;
    end
  end

  assign digits = (r_state == LAP) ? r_freeze : w_count;
`else
  assign digits = w_count;
`endif

  assign running    = r_running;
  assign wrap_pulse = r_wrap;

endmodule

`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter MAX_MIN, default 9: highest minutes value before wrap (1..9).
REQ-002 SHALL have port clock_5  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tick_in  input  1  one-cycle enable pulse from the upstream clock divider; one pulse = 0.1 s.
REQ-005 SHALL have port key_start_n  input  1  raw active-low start/stop pushbutton, asynchronous to clock_5.
REQ-006 SHALL have port key_clear_n  input  1  raw active-low clear/lap pushbutton, asynchronous to clock_5.
REQ-007 SHALL have port digits  output  16  BCD display value {minutes[15:12], sec_tens[11:8], sec_units[7:4], tenths[3:0]}.
REQ-008 SHALL have port running  output  1  high while state is RUN (or LAP).
REQ-009 SHALL have port wrap_pulse  output  1  one-cycle pulse when the count wraps MAX_MIN:59.9 -> 0:00.0.

Function
REQ-010 SHALL pass each key through a two-flop synchronizer, then a falling-edge detector: one event per press, regardless of hold duration.
REQ-011 SHALL act on a key event at the 3rd rising edge after the pin is sampled low; no extra delay.
REQ-012 SHALL implement states IDLE, RUN, PAUSE: IDLE+start -> RUN; RUN+start -> PAUSE; PAUSE+start -> RUN; PAUSE+clear -> IDLE with count zeroed; clear in IDLE or RUN ignored.
REQ-013 SHALL increment the count by 0.1 s on every cycle with tick_in=1 while the registered state is RUN (or LAP); ticks in IDLE/PAUSE are ignored.
REQ-014 SHALL count in BCD: tenths 0-9, sec_units 0-9, sec_tens 0-5, minutes 0-MAX_MIN; each carry in the same cycle as the tick; no binary intermediate.
REQ-015 SHALL wrap MAX_MIN:59.9 + tick -> 0:00.0, assert wrap_pulse exactly that next cycle, and stay in RUN.
REQ-016 SHALL resolve same-cycle start and clear events by processing start and dropping clear.
REQ-017 SHALL count a tick coinciding with RUN->PAUSE; SHALL NOT count a tick coinciding with PAUSE->RUN.
REQ-018 SHALL drive digits, running and wrap_pulse from registers (no combinational path from inputs).

Reset
REQ-019 SHALL, on reset low, immediately force state IDLE, count 0:00.0, digits 16'h0000, running 0, wrap_pulse 0, synchronizer flops 1 (released).
REQ-020 SHALL abandon any run in progress on reset mid-operation; after release, SHALL need a new press to start; a key held low across release SHALL NOT create an event.

Configuration
REQ-021 SHALL support macro STOPWATCH_LAP_EN; when defined, adds state LAP: RUN+clear -> LAP (digits frozen at the value of the transition cycle, counting continues, running=1); LAP+clear -> RUN (digits track live count next cycle); LAP+start -> PAUSE with digits showing the live count.
REQ-022 SHALL, without STOPWATCH_LAP_EN, contain no LAP state or freeze register, and clear in RUN is ignored.

Structure
REQ-023 SHALL place the state enum (IDLE, RUN, PAUSE, LAP), BCD digit width (4) and digit limits (9, 5) in shared package stopwatch_pkg.
REQ-024 SHALL instantiate sub-module bcd_digit (parameterised limit, inc in, carry out, clear) four times as a ripple chain.

Verification
REQ-025 SHALL test: reset, press start, 25 ticks -> digits=16'h0025 (0:02.5), running=1.
REQ-026 SHALL test: preload 9:59.9 in RUN, one tick -> digits=16'h0000, wrap_pulse high exactly one cycle, running=1.
REQ-027 SHALL test: start, 7 ticks, start (pause), 5 ticks, clear -> digits 16'h0007 during pause, then 16'h0000 and IDLE.
REQ-028 SHALL test: start and clear pressed in the same cycle from PAUSE at 16'h0012 -> RUN, count retained at 16'h0012.
REQ-029 SHALL test: reset asserted mid-run at 16'h0340 with start held low -> 16'h0000 at once, IDLE; no start until start released and re-pressed.
REQ-030 SHALL test with STOPWATCH_LAP_EN: run to 16'h0010, clear, 30 ticks -> digits stay 16'h0010; clear -> digits 16'h0040.
